// File: rtl/taiko_pkg.sv
// Shared constants, encodings and types for the do/ka note judge.
package taiko_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned XW    = 10;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = PW + 1;

  localparam logic [XW-1:0] SPAWN_X   = XW'(640);
  localparam logic [XW-1:0] HIT_X     = XW'(100);
  localparam logic [XW-1:0] SPEED     = XW'(4);
  localparam logic [XW-1:0] GREAT_WIN = XW'(8);
  localparam logic [XW-1:0] GOOD_WIN  = XW'(20);
  localparam logic [XW-1:0] EXPIRE_X  = HIT_X - GOOD_WIN;

  localparam logic [1:0] JUDGE_GREAT = 2'b01;
  localparam logic [1:0] JUDGE_GOOD  = 2'b10;
  localparam logic [1:0] JUDGE_MISS  = 2'b11;

  localparam logic NOTE_DO = 1'b0;
  localparam logic NOTE_KA = 1'b1;

  localparam logic [15:0] SCORE_GREAT = 16'd300;
  localparam logic [15:0] SCORE_GOOD  = 16'd100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    EXPIRE = 2'd2
  } state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic          ka;
  } note_t;

  function automatic logic [XW-1:0] abs_diff(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/note_queue.sv
// Circular note store: tail push, head pop, plus one indexed read/modify port for the scroller.
module note_queue
  import taiko_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [XW-1:0] push_x,
  input  logic          push_ka,
  input  logic          pop,
  input  logic [PW-1:0] walk_idx,
  input  logic          walk_we,
  input  logic [XW-1:0] walk_wx,
  output logic [XW-1:0] walk_x_c,
  output logic [XW-1:0] head_x_c,
  output logic          head_ka_c,
  output logic [PW-1:0] head_idx,
  output logic [CW-1:0] count,
  output logic          full_c,
  output logic          empty_c
);

  note_t [DEPTH-1:0] mem_q, mem_d;
  logic  [PW-1:0]    head_q, head_d;
  logic  [PW-1:0]    tail_q, tail_d;
  logic  [CW-1:0]    count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CW'(DEPTH));
  assign head_x_c  = mem_q[head_q].x;
  assign head_ka_c = mem_q[head_q].ka;
  assign walk_x_c  = mem_q[walk_idx].x;
  assign head_idx  = head_q;
  assign count     = count_q;

  // A pop frees a slot in the same cycle, so a push into a full queue survives a concurrent pop.
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (walk_we) begin
      mem_d[walk_idx].x = walk_wx;
    end
    if (push_ok) begin
      mem_d[tail_q].x  = push_x;
      mem_d[tail_q].ka = push_ka;
      tail_d           = tail_q + PW'(1);
    end
    if (pop_ok) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/note_judge.sv
// Note scroller and hit judge: spawns, scrolls and expires notes, judges do/ka hits, keeps combo/score.
// Build option NOTE_AUTOPLAY_EN: ignore player hits and auto-hit every note at the GREAT window.
module note_judge
  import taiko_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic [1:0]    request,
  input  logic          hit_do,
  input  logic          hit_ka,
  output logic          head_valid,
  output logic [XW-1:0] head_x,
  output logic          head_ka,
  output logic [CW-1:0] note_count,
  output logic          judge_valid,
  output logic [1:0]    judge_res,
  output logic [7:0]    combo,
  output logic [15:0]   score,
  output logic          overflow
);

  state_e        state_q, state_d;
  logic [PW-1:0] walk_idx_q, walk_idx_d;
  logic [CW-1:0] walk_cnt_q, walk_cnt_d;
  logic [CW-1:0] walk_lim_q, walk_lim_d;
  logic          pend_do_q, pend_do_d;
  logic          pend_ka_q, pend_ka_d;
  logic          judge_valid_q, judge_valid_d;
  logic [1:0]    judge_res_q, judge_res_d;
  logic [7:0]    combo_q, combo_d;
  logic [15:0]   score_q, score_d;
  logic          overflow_q, overflow_d;
  logic          head_valid_q, head_valid_d;
  logic [XW-1:0] head_x_q, head_x_d;
  logic          head_ka_q, head_ka_d;
  logic [CW-1:0] note_count_q, note_count_d;

  logic          spawn_c, spawn_ka_c;
  logic          pop_c, walk_we_c;
  logic [XW-1:0] walk_wx_c, walk_x_c;
  logic [XW-1:0] q_head_x_c;
  logic          q_head_ka_c, q_full_c, q_empty_c;
  logic [PW-1:0] q_head_idx;
  logic [CW-1:0] q_count;
  logic [XW-1:0] dist_c;
  logic          in_win_c;
  logic          hit_any_c, hit_ka_sel_c;
  logic [15:0]   score_inc_c;
  logic [16:0]   score_sum_c;

  // request==2'b11 resolves to a do note.
  assign spawn_c    = |request;
  assign spawn_ka_c = request[0] ? NOTE_DO : NOTE_KA;

  assign dist_c   = abs_diff(q_head_x_c, HIT_X);
  assign in_win_c = !q_empty_c && (dist_c <= GOOD_WIN);

  note_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (spawn_c),
    .push_x   (SPAWN_X),
    .push_ka  (spawn_ka_c),
    .pop      (pop_c),
    .walk_idx (walk_idx_q),
    .walk_we  (walk_we_c),
    .walk_wx  (walk_wx_c),
    .walk_x_c (walk_x_c),
    .head_x_c (q_head_x_c),
    .head_ka_c(q_head_ka_c),
    .head_idx (q_head_idx),
    .count    (q_count),
    .full_c   (q_full_c),
    .empty_c  (q_empty_c)
  );

`ifdef NOTE_AUTOPLAY_EN
  logic unused_hits_c;
  assign unused_hits_c = hit_do ^ hit_ka;
`endif

  always_comb begin
    state_d       = state_q;
    walk_idx_d    = walk_idx_q;
    walk_cnt_d    = walk_cnt_q;
    walk_lim_d    = walk_lim_q;
    pend_do_d     = pend_do_q;
    pend_ka_d     = pend_ka_q;
    judge_valid_d = 1'b0;
    judge_res_d   = judge_res_q;
    combo_d       = combo_q;
    score_d       = score_q;
    overflow_d    = overflow_q;
    pop_c         = 1'b0;
    walk_we_c     = 1'b0;
    walk_wx_c     = (walk_x_c < SPEED) ? '0 : (walk_x_c - SPEED);
    hit_any_c     = 1'b0;
    hit_ka_sel_c  = NOTE_DO;
    score_inc_c   = '0;
    score_sum_c   = '0;

`ifndef NOTE_AUTOPLAY_EN
    pend_do_d = pend_do_q | hit_do;
    pend_ka_d = pend_ka_q | hit_ka;
`endif

    case (state_q)
      IDLE: begin
`ifdef NOTE_AUTOPLAY_EN
        hit_any_c    = !q_empty_c && (dist_c <= GREAT_WIN);
        hit_ka_sel_c = q_head_ka_c;
`else
        // One pending hit per cycle, do first; a hit outside the window is simply dropped.
        if (pend_do_d) begin
          pend_do_d    = 1'b0;
          hit_any_c    = 1'b1;
          hit_ka_sel_c = NOTE_DO;
        end else if (pend_ka_d) begin
          pend_ka_d    = 1'b0;
          hit_any_c    = 1'b1;
          hit_ka_sel_c = NOTE_KA;
        end
`endif
        if (hit_any_c && in_win_c) begin
          pop_c         = 1'b1;
          judge_valid_d = 1'b1;
          if (hit_ka_sel_c != q_head_ka_c) begin
            judge_res_d = JUDGE_MISS;
          end else if (dist_c <= GREAT_WIN) begin
            judge_res_d = JUDGE_GREAT;
          end else begin
            judge_res_d = JUDGE_GOOD;
          end
        end
        // Snapshot excludes a head popped in this same cycle.
        if (vsync) begin
          state_d    = MOVE;
          walk_idx_d = q_head_idx + PW'(pop_c);
          walk_cnt_d = '0;
          walk_lim_d = q_count - CW'(pop_c);
        end
      end
      MOVE: begin
        if (walk_cnt_q == walk_lim_q) begin
          state_d = EXPIRE;
        end else begin
          walk_we_c  = 1'b1;
          walk_idx_d = walk_idx_q + PW'(1);
          walk_cnt_d = walk_cnt_q + CW'(1);
        end
      end
      EXPIRE: begin
        if (!q_empty_c && (q_head_x_c < EXPIRE_X)) begin
          pop_c         = 1'b1;
          judge_valid_d = 1'b1;
          judge_res_d   = JUDGE_MISS;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (judge_valid_d) begin
      if (judge_res_d == JUDGE_GREAT) begin
        score_inc_c = SCORE_GREAT;
      end else if (judge_res_d == JUDGE_GOOD) begin
        score_inc_c = SCORE_GOOD;
      end
      score_sum_c = {1'b0, score_q} + {1'b0, score_inc_c};
      score_d     = score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
      if (judge_res_d == JUDGE_MISS) begin
        combo_d = '0;
      end else if (combo_q != 8'hFF) begin
        combo_d = combo_q + 8'd1;
      end
    end

    if (spawn_c && q_full_c && !pop_c) begin
      overflow_d = 1'b1;
    end

    head_valid_d = !q_empty_c;
    head_x_d     = q_empty_c ? '0 : q_head_x_c;
    head_ka_d    = q_empty_c ? 1'b0 : q_head_ka_c;
    note_count_d = q_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      walk_idx_q    <= '0;
      walk_cnt_q    <= '0;
      walk_lim_q    <= '0;
      pend_do_q     <= 1'b0;
      pend_ka_q     <= 1'b0;
      judge_valid_q <= 1'b0;
      judge_res_q   <= '0;
      combo_q       <= '0;
      score_q       <= '0;
      overflow_q    <= 1'b0;
      head_valid_q  <= 1'b0;
      head_x_q      <= '0;
      head_ka_q     <= 1'b0;
      note_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      walk_idx_q    <= walk_idx_d;
      walk_cnt_q    <= walk_cnt_d;
      walk_lim_q    <= walk_lim_d;
      pend_do_q     <= pend_do_d;
      pend_ka_q     <= pend_ka_d;
      judge_valid_q <= judge_valid_d;
      judge_res_q   <= judge_res_d;
      combo_q       <= combo_d;
      score_q       <= score_d;
      overflow_q    <= overflow_d;
      head_valid_q  <= head_valid_d;
      head_x_q      <= head_x_d;
      head_ka_q     <= head_ka_d;
      note_count_q  <= note_count_d;
    end
  end

  assign head_valid  = head_valid_q;
  assign head_x      = head_x_q;
  assign head_ka     = head_ka_q;
  assign note_count  = note_count_q;
  assign judge_valid = judge_valid_q;
  assign judge_res   = judge_res_q;
  assign combo       = combo_q;
  assign score       = score_q;
  assign overflow    = overflow_q;

endmodule
